trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//  Trap sequencer between the commit stage and the CSR file. It detects exceptions, pending
//  interrupts and MRET on the committing instruction. It drains and flushes the pipeline,
//  then drives the CSR file's trap/MRET update (mepc/mcause/mtval, mstatus stacking).
//  Finally it redirects fetch to the mtvec or mepc target.
// PARAMETERS
//  RESET_PC  32'h0000_0000  unused by FSM; reported on redirect_pc_o at reset
// PORTS
//  clk_i             in   1   clock
//  rst_i             in   1   reset, synchronous, active-high
//  commit_valid_i    in   1   instruction at commit stage is valid
//  commit_pc_i       in   32  its PC
//  commit_instr_i    in   32  its encoding (for mtval on illegal)
//  exc_ifetch_mis_i  in   1   instruction-address misaligned
//  exc_illegal_i     in   1   illegal instruction
//  exc_ebreak_i      in   1   EBREAK
//  exc_ecall_i       in   1   ECALL from M-mode
//  exc_ld_mis_i      in   1   load-address misaligned
//  exc_st_mis_i      in   1   store/AMO-address misaligned
//  exc_addr_i        in   32  faulting address for misaligned cases
//  mret_i            in   1   committing instruction is MRET
//  wfi_i             in   1   committing instruction is WFI
//  irq_i             in   32  mip view: bit 3 MSI, 7 MTI, 11 MEI; others ignored
//  mie_i             in   32  mie CSR value
//  mstatus_mie_i     in   1   mstatus.MIE
//  mtvec_i           in   32  mtvec CSR value
//  mepc_i            in   32  mepc CSR value
//  lsu_idle_i        in   1   no outstanding memory transaction
//  stall_o           out  1   freeze fetch/decode/execute
//  flush_o           out  1   squash all in-flight instructions
//  trap_o            out  1   1-cycle strobe: CSR file captures mepc/mcause/mtval, stacks mstatus
//  mret_o            out  1   1-cycle strobe to CSR file (csr_mret)
//  mepc_o            out  32  value for mepc, valid with trap_o
//  mcause_o          out  32  value for mcause, valid with trap_o
//  mtval_o           out  32  value for mtval, valid with trap_o
//  redirect_valid_o  out  1   1-cycle strobe: fetch jumps to redirect_pc_o
//  redirect_pc_o     out  32  redirect target
// BEHAVIOUR
//  Reset: state IDLE; every output 0 except redirect_pc_o=RESET_PC. Reset mid-sequence aborts it; no strobe follows.
//  Event check runs only in IDLE with commit_valid_i=1. The check takes the first matching rule, in this order:
//  1. Interrupt: mstatus_mie_i & |(irq_i & mie_i & 32'h888). Priority is MEI(11) > MSI(3) > MTI(7).
//     The instruction is squashed. mepc=commit_pc_i.
//  2. Exception, by priority: ifetch_mis(0) > illegal(2) > ebreak(3) > ecall(11) > ld_mis(4) > st_mis(6).
//     mepc=commit_pc_i.
//  3. MRET.
//  4. WFI (see CONFIGURATION).
//  In all other states the commit_* inputs, exc_* inputs, mret_i and wfi_i are ignored.
//  mcause = {is_irq, 27'b0, code[3:0]}.
//  mtval by cause: illegal -> commit_instr_i; ifetch/ld/st misaligned -> exc_addr_i; all others -> 0.
//  Cause, PC and tval are latched at detection.
//  FSM transitions:
//   IDLE ->DRAIN on event.
//   DRAIN: stall_o=1 and flush_o=1. Stay while !lsu_idle_i; go to ENTER when lsu_idle_i=1.
//   ENTER: stall_o=1 for 1 cycle, with exactly one of trap_o or mret_o. Next state REDIRECT.
//   REDIRECT: stall_o=1 and redirect_valid_o=1 for 1 cycle. Next state IDLE.
//  Minimum latency: detection cycle N -> trap_o at N+2 -> redirect_valid_o at N+3.
//  Redirect target:
//   MRET: mepc_i sampled in ENTER.
//   Trap: base={mtvec_i[31:2],2'b00}. If mtvec_i[1:0]==1 and is_irq, target = base + 4*code.
//   mtvec_i[1:0] values 0, 2 and 3 select direct mode.
//   Target arithmetic is modulo 2^32; wrap-around is allowed.
// CONFIGURATION
//  YARC_TRAP_WFI_EN defined:
//   WFI with no interrupt or exception goes from IDLE to SLEEP, holding stall_o=1.
//   SLEEP exits when |(irq_i & mie_i & 32'h888), regardless of mstatus_mie_i.
//   If mstatus_mie_i=1 on exit: take the interrupt path (DRAIN...) with mepc = WFI pc + 4.
//   If mstatus_mie_i=0 on exit: drop stall_o and return to IDLE; execution continues.
//  YARC_TRAP_WFI_EN undefined: WFI commits as a NOP; the SLEEP state does not exist.
// STRUCTURE
//  csr_pkg holds: exc_cause_e codes (0,2,3,4,6,11), irq codes (3,7,11), MTVEC_MODE_VECTORED=2'b01.
//  trap_state_e stays local to this module.
//  Sub-module trap_cause_prio: combinational priority encoder taking the irq/exc vectors and
//  returning is_irq, code and valid.
// TESTING
//  ecall at pc=0x100, mtvec=0x800, lsu_idle_i=1 -> trap_o at N+2 with mcause=0xB, mepc=0x100, mtval=0;
//   redirect to 0x800 at N+3.
//  illegal instr=0xFFFF_FFFF at pc=0x40 -> mcause=2, mtval=0xFFFF_FFFF.
//  MTI+MEI pending, mie=0x880, mstatus_mie_i=1, mtvec=0x1001 -> mcause=0x8000_000B,
//   redirect=0x102C; repeat with mstatus_mie_i=0 -> no trap.
//  mret with mepc=0x200, lsu_idle_i low for 3 cycles -> DRAIN held 4 cycles, then mret_o,
//   then redirect=0x200.
//  ld_mis and illegal on the same commit -> mcause=2; rst_i asserted during DRAIN ->
//   no trap_o/redirect, all outputs 0.
//  WFI with YARC_TRAP_WFI_EN, pc=0x300: stall until irq_i[7]&mie_i[7]; with mstatus_mie_i=1
//   -> mepc=0x304.

Source files
------------

// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
//   Shared trap/CSR encodings used by the trap sequencer:
//     exc_cause_e          synchronous exception cause codes (mcause[3:0])
//     IRQ_MSI/MTI/MEI      machine interrupt cause codes
//     IRQ_MASK             mip/mie bits the trap logic reacts to
//     MTVEC_MODE_VECTORED  mtvec[1:0] encoding for vectored mode
//     trap_target()        mtvec-based trap entry address
// ---------------------------------------------------------------------------
package csr_pkg;

    typedef enum logic [3:0] {
        EXC_IFETCH_MIS = 4'd0,
        EXC_ILLEGAL    = 4'd2,
        EXC_BREAKPOINT = 4'd3,
        EXC_LD_MIS     = 4'd4,
        EXC_ST_MIS     = 4'd6,
        EXC_ECALL_M    = 4'd11
    } exc_cause_e;

    localparam logic [3:0]  IRQ_MSI = 4'd3;
    localparam logic [3:0]  IRQ_MTI = 4'd7;
    localparam logic [3:0]  IRQ_MEI = 4'd11;
    localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

    localparam logic [1:0]  MTVEC_MODE_VECTORED = 2'b01;

    // Only interrupts are vectored; every other mode value (0, 2, 3) is direct.
    // The add wraps modulo 2^32 by construction.
    function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                                input logic        is_irq,
                                                input logic [3:0]  code);
        logic [31:0] base;
        base = {mtvec[31:2], 2'b00};
        if (mtvec[1:0] == MTVEC_MODE_VECTORED && is_irq)
            return base + {26'b0, code, 2'b00};
        return base;
    endfunction

endpackage

// File: rtl/trap_cause_prio.sv
// ---------------------------------------------------------------------------
// trap_cause_prio
//   Combinational priority encoder for trap causes. Interrupts always win
//   over exceptions; the caller gates irq_pend_i with the global enable.
//   Ports:
//     irq_pend_i        in  32  pending & enabled interrupts (bits 3/7/11)
//     exc_*_i           in  1   exception flags of the committing instruction
//     valid_o           out 1   some cause is present
//     is_irq_o          out 1   winning cause is an interrupt
//     code_o            out 4   winning cause code
// ---------------------------------------------------------------------------
module trap_cause_prio
    import csr_pkg::*;
(
    input  logic [31:0] irq_pend_i,
    input  logic        exc_ifetch_mis_i,
    input  logic        exc_illegal_i,
    input  logic        exc_ebreak_i,
    input  logic        exc_ecall_i,
    input  logic        exc_ld_mis_i,
    input  logic        exc_st_mis_i,
    output logic        valid_o,
    output logic        is_irq_o,
    output logic [3:0]  code_o
);

    always_comb begin
        valid_o  = 1'b1;
        is_irq_o = 1'b0;
        code_o   = 4'd0;
        // Interrupt order MEI > MSI > MTI.
        if (irq_pend_i[11]) begin
            is_irq_o = 1'b1;
            code_o   = IRQ_MEI;
        end else if (irq_pend_i[3]) begin
            is_irq_o = 1'b1;
            code_o   = IRQ_MSI;
        end else if (irq_pend_i[7]) begin
            is_irq_o = 1'b1;
            code_o   = IRQ_MTI;
        end else if (exc_ifetch_mis_i) begin
            code_o   = EXC_IFETCH_MIS;
        end else if (exc_illegal_i) begin
            code_o   = EXC_ILLEGAL;
        end else if (exc_ebreak_i) begin
            code_o   = EXC_BREAKPOINT;
        end else if (exc_ecall_i) begin
            code_o   = EXC_ECALL_M;
        end else if (exc_ld_mis_i) begin
            code_o   = EXC_LD_MIS;
        end else if (exc_st_mis_i) begin
            code_o   = EXC_ST_MIS;
        end else begin
            valid_o  = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
//   Trap sequencer between commit and the CSR file. On an interrupt,
//   exception or MRET at commit it drains/flushes the pipe, strobes the CSR
//   update (trap_o or mret_o) and then redirects fetch.
//   Sequence: IDLE -> DRAIN (until lsu idle) -> ENTER -> REDIRECT -> IDLE.
//   Optional feature macro YARC_TRAP_WFI_EN adds a SLEEP state for WFI;
//   without it WFI is a NOP.
//   Ports:
//     clk_i, rst_i                   clock, sync active-high reset
//     commit_*_i, exc_*_i            committing instruction and its faults
//     mret_i, wfi_i                  committing instruction is MRET / WFI
//     irq_i, mie_i, mstatus_mie_i    interrupt pending / enables
//     mtvec_i, mepc_i                CSR values for redirect targets
//     lsu_idle_i                     no outstanding memory transaction
//     stall_o, flush_o               pipeline control
//     trap_o, mret_o                 1-cycle CSR update strobes
//     mepc_o, mcause_o, mtval_o      CSR values, valid with trap_o
//     redirect_valid_o/_pc_o         fetch redirect
// ---------------------------------------------------------------------------
module trap_ctrl
    import csr_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        commit_valid_i,
    input  logic [31:0] commit_pc_i,
    input  logic [31:0] commit_instr_i,
    input  logic        exc_ifetch_mis_i,
    input  logic        exc_illegal_i,
    input  logic        exc_ebreak_i,
    input  logic        exc_ecall_i,
    input  logic        exc_ld_mis_i,
    input  logic        exc_st_mis_i,
    input  logic [31:0] exc_addr_i,
    input  logic        mret_i,
    input  logic        wfi_i,
    input  logic [31:0] irq_i,
    input  logic [31:0] mie_i,
    input  logic        mstatus_mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic        lsu_idle_i,
    output logic        stall_o,
    output logic        flush_o,
    output logic        trap_o,
    output logic        mret_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mcause_o,
    output logic [31:0] mtval_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_ENTER,
`ifdef YARC_TRAP_WFI_EN
        ST_SLEEP,
`endif
        ST_REDIRECT
    } trap_state_e;

    trap_state_e state_q;
    logic        stall_q, flush_q, trap_q, mret_q, rvalid_q, is_mret_q;
    logic [31:0] rpc_q, mepc_q, mcause_q, mtval_q;

    logic [31:0] irq_raw, irq_en, mtval_d;
    logic        prio_valid, prio_is_irq;
    logic [3:0]  prio_code;

    // irq_raw ignores mstatus.MIE so it can also serve as the WFI wake-up.
    assign irq_raw = irq_i & mie_i & IRQ_MASK;
    assign irq_en  = irq_raw & {32{mstatus_mie_i}};

    trap_cause_prio u_prio (
        .irq_pend_i       (irq_en),
        .exc_ifetch_mis_i (exc_ifetch_mis_i),
        .exc_illegal_i    (exc_illegal_i),
        .exc_ebreak_i     (exc_ebreak_i),
        .exc_ecall_i      (exc_ecall_i),
        .exc_ld_mis_i     (exc_ld_mis_i),
        .exc_st_mis_i     (exc_st_mis_i),
        .valid_o          (prio_valid),
        .is_irq_o         (prio_is_irq),
        .code_o           (prio_code)
    );

    always_comb begin
        mtval_d = 32'd0;
        if (!prio_is_irq) begin
            case (prio_code)
                EXC_ILLEGAL:                          mtval_d = commit_instr_i;
                EXC_IFETCH_MIS, EXC_LD_MIS, EXC_ST_MIS: mtval_d = exc_addr_i;
                default:                              mtval_d = 32'd0;
            endcase
        end
    end

`ifndef YARC_TRAP_WFI_EN
    logic unused_wfi;
    assign unused_wfi = wfi_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            stall_q   <= 1'b0;
            flush_q   <= 1'b0;
            trap_q    <= 1'b0;
            mret_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            is_mret_q <= 1'b0;
            rpc_q     <= RESET_PC;
            mepc_q    <= 32'd0;
            mcause_q  <= 32'd0;
            mtval_q   <= 32'd0;
        end else begin
            trap_q   <= 1'b0;
            mret_q   <= 1'b0;
            rvalid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (commit_valid_i) begin
                        if (prio_valid) begin
                            state_q   <= ST_DRAIN;
                            stall_q   <= 1'b1;
                            flush_q   <= 1'b1;
                            is_mret_q <= 1'b0;
                            mepc_q    <= commit_pc_i;
                            mcause_q  <= {prio_is_irq, 27'b0, prio_code};
                            mtval_q   <= mtval_d;
                        end else if (mret_i) begin
                            state_q   <= ST_DRAIN;
                            stall_q   <= 1'b1;
                            flush_q   <= 1'b1;
                            is_mret_q <= 1'b1;
                        end
`ifdef YARC_TRAP_WFI_EN
                        else if (wfi_i) begin
                            // Resume point is the instruction after WFI.
                            state_q <= ST_SLEEP;
                            stall_q <= 1'b1;
                            mepc_q  <= commit_pc_i + 32'd4;
                        end
`endif
                    end
                end
                ST_DRAIN: begin
                    if (lsu_idle_i) begin
                        state_q <= ST_ENTER;
                        flush_q <= 1'b0;
                        trap_q  <= !is_mret_q;
                        mret_q  <= is_mret_q;
                    end
                end
                ST_ENTER: begin
                    state_q  <= ST_REDIRECT;
                    rvalid_q <= 1'b1;
                    rpc_q    <= is_mret_q ? mepc_i
                                          : trap_target(mtvec_i, mcause_q[31], mcause_q[3:0]);
                end
                ST_REDIRECT: begin
                    state_q <= ST_IDLE;
                    stall_q <= 1'b0;
                end
`ifdef YARC_TRAP_WFI_EN
                ST_SLEEP: begin
                    if (|irq_raw) begin
                        if (mstatus_mie_i) begin
                            // irq_en == irq_raw here, so the encoder yields the interrupt.
                            state_q   <= ST_DRAIN;
                            flush_q   <= 1'b1;
                            is_mret_q <= 1'b0;
                            mcause_q  <= {1'b1, 27'b0, prio_code};
                            mtval_q   <= 32'd0;
                        end else begin
                            state_q <= ST_IDLE;
                            stall_q <= 1'b0;
                        end
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall_o          = stall_q;
    assign flush_o          = flush_q;
    assign trap_o           = trap_q;
    assign mret_o           = mret_q;
    assign mepc_o           = mepc_q;
    assign mcause_o         = mcause_q;
    assign mtval_o          = mtval_q;
    assign redirect_valid_o = rvalid_q;
    assign redirect_pc_o    = rpc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl
//   Transaction-level model of the trap sequencer: each commit is classified
//   into an event (none / trap / mret / sleep) with its CSR values and target,
//   and the expected cycle-by-cycle output trace is laid out from that.
// ---------------------------------------------------------------------------
module tb_trap_ctrl;

    localparam logic [31:0] RPC = 32'h1000_0000;

    logic        clk, rst;
    logic        commit_valid_i;
    logic [31:0] commit_pc_i, commit_instr_i, exc_addr_i;
    logic        exc_ifetch_mis_i, exc_illegal_i, exc_ebreak_i, exc_ecall_i;
    logic        exc_ld_mis_i, exc_st_mis_i, mret_i, wfi_i;
    logic [31:0] irq_i, mie_i, mtvec_i, mepc_i;
    logic        mstatus_mie_i, lsu_idle_i;
    logic        stall_o, flush_o, trap_o, mret_o, redirect_valid_o;
    logic [31:0] mepc_o, mcause_o, mtval_o, redirect_pc_o;

    trap_ctrl #(.RESET_PC(RPC)) dut (
        .clk_i(clk), .rst_i(rst),
        .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i), .commit_instr_i(commit_instr_i),
        .exc_ifetch_mis_i(exc_ifetch_mis_i), .exc_illegal_i(exc_illegal_i), .exc_ebreak_i(exc_ebreak_i),
        .exc_ecall_i(exc_ecall_i), .exc_ld_mis_i(exc_ld_mis_i), .exc_st_mis_i(exc_st_mis_i),
        .exc_addr_i(exc_addr_i), .mret_i(mret_i), .wfi_i(wfi_i),
        .irq_i(irq_i), .mie_i(mie_i), .mstatus_mie_i(mstatus_mie_i),
        .mtvec_i(mtvec_i), .mepc_i(mepc_i), .lsu_idle_i(lsu_idle_i),
        .stall_o(stall_o), .flush_o(flush_o), .trap_o(trap_o), .mret_o(mret_o),
        .mepc_o(mepc_o), .mcause_o(mcause_o), .mtval_o(mtval_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Expected outputs for the current cycle.
    logic        chk_en = 1'b0;
    logic        e_stall, e_flush, e_trap, e_mret, e_rv;
    logic        e_data_chk, e_pc_chk;
    logic [31:0] e_mepc, e_mcause, e_mtval, e_rpc;

    typedef struct {
        int          kind;   // 0 none, 1 trap, 2 mret, 3 sleep
        logic [31:0] mcause, mepc, mtval, target;
    } ev_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_o", {31'b0, stall_o}, {31'b0, e_stall});
            chk("flush_o", {31'b0, flush_o}, {31'b0, e_flush});
            chk("trap_o", {31'b0, trap_o}, {31'b0, e_trap});
            chk("mret_o", {31'b0, mret_o}, {31'b0, e_mret});
            chk("redirect_valid_o", {31'b0, redirect_valid_o}, {31'b0, e_rv});
            if (e_data_chk) begin
                chk("mepc_o", mepc_o, e_mepc);
                chk("mcause_o", mcause_o, e_mcause);
                chk("mtval_o", mtval_o, e_mtval);
            end
            if (e_pc_chk) chk("redirect_pc_o", redirect_pc_o, e_rpc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_ctl(input logic s, input logic f, input logic t, input logic m, input logic r);
        e_stall = s; e_flush = f; e_trap = t; e_mret = m; e_rv = r;
        e_data_chk = 1'b0; e_pc_chk = 1'b0;
    endtask

    task automatic clear_commit();
        commit_valid_i = 0; commit_pc_i = 0; commit_instr_i = 0; exc_addr_i = 0;
        exc_ifetch_mis_i = 0; exc_illegal_i = 0; exc_ebreak_i = 0; exc_ecall_i = 0;
        exc_ld_mis_i = 0; exc_st_mis_i = 0; mret_i = 0; wfi_i = 0;
    endtask

    task automatic clear_all();
        clear_commit();
        irq_i = 0; mie_i = 0; mstatus_mie_i = 0; mtvec_i = 0; mepc_i = 0; lsu_idle_i = 1;
    endtask

    // Commit-side noise while the sequencer is busy; it must be ignored.
    task automatic garbage();
        commit_valid_i = 1'($urandom); commit_pc_i = $urandom; commit_instr_i = $urandom;
        exc_addr_i = $urandom;
        exc_ifetch_mis_i = 1'($urandom); exc_illegal_i = 1'($urandom); exc_ebreak_i = 1'($urandom);
        exc_ecall_i = 1'($urandom); exc_ld_mis_i = 1'($urandom); exc_st_mis_i = 1'($urandom);
        mret_i = 1'($urandom); wfi_i = 1'($urandom);
    endtask

    // Classify the commit currently on the inputs.
    function automatic ev_t model();
        ev_t e;
        logic [31:0] p;
        logic [3:0]  code;
        logic        irq, hit;
        e.kind = 0; e.mcause = 0; e.mepc = 0; e.mtval = 0; e.target = 0;
        hit = 0; irq = 0; code = 0;
        p = irq_i & mie_i & 32'h888;
        if (!commit_valid_i) return e;
        if (mstatus_mie_i && p != 0) begin
            hit = 1; irq = 1;
            code = p[11] ? 4'd11 : (p[3] ? 4'd3 : 4'd7);
        end
        else if (exc_ifetch_mis_i) begin hit = 1; code = 0;  e.mtval = exc_addr_i; end
        else if (exc_illegal_i)    begin hit = 1; code = 2;  e.mtval = commit_instr_i; end
        else if (exc_ebreak_i)     begin hit = 1; code = 3; end
        else if (exc_ecall_i)      begin hit = 1; code = 11; end
        else if (exc_ld_mis_i)     begin hit = 1; code = 4;  e.mtval = exc_addr_i; end
        else if (exc_st_mis_i)     begin hit = 1; code = 6;  e.mtval = exc_addr_i; end
        if (hit) begin
            e.kind   = 1;
            e.mcause = (irq ? 32'h8000_0000 : 32'd0) + 32'(code);
            e.mepc   = commit_pc_i;
            e.target = (mtvec_i & 32'hFFFF_FFFC) +
                       ((irq && mtvec_i[1:0] == 2'd1) ? 32'(code) * 4 : 32'd0);
        end
        else if (mret_i) begin
            e.kind = 2; e.target = mepc_i;
        end
`ifdef YARC_TRAP_WFI_EN
        else if (wfi_i) e.kind = 3;
`endif
        return e;
    endfunction

    // Expected trace from the first DRAIN cycle onward; d = lsu-busy cycles.
    task automatic seq_tail(input ev_t e, input int d);
        for (int i = 0; i <= d; i++) begin
            garbage();
            lsu_idle_i = (i == d);
            exp_ctl(1, 1, 0, 0, 0);
            step();
        end
        garbage();
        lsu_idle_i = 1'($urandom);
        exp_ctl(1, 0, e.kind == 1, e.kind == 2, 0);
        if (e.kind == 1) begin
            e_data_chk = 1; e_mepc = e.mepc; e_mcause = e.mcause; e_mtval = e.mtval;
        end
        step();
        garbage();
        exp_ctl(1, 0, 0, 0, 1);
        e_pc_chk = 1; e_rpc = e.target;
        step();
        clear_commit();
        exp_ctl(0, 0, 0, 0, 0);
        step();
    endtask

    task automatic run_txn(input ev_t e, input int d);
        exp_ctl(0, 0, 0, 0, 0);
        step();
        if (e.kind == 1 || e.kind == 2) seq_tail(e, d);
        else begin
            clear_commit();
            exp_ctl(0, 0, 0, 0, 0);
            step();
        end
    endtask

    // Literal expectation also pins the model.
    task automatic directed(input string nm, input ev_t lit, input int d);
        ev_t m;
        m = model();
        chk({nm, "_model_kind"}, 32'(m.kind), 32'(lit.kind));
        chk({nm, "_model_mcause"}, m.mcause, lit.mcause);
        chk({nm, "_model_target"}, m.target, lit.target);
        run_txn(lit, d);
    endtask

    function automatic ev_t mk(input int k, input logic [31:0] c, input logic [31:0] pc,
                               input logic [31:0] tv, input logic [31:0] tg);
        ev_t e;
        e.kind = k; e.mcause = c; e.mepc = pc; e.mtval = tv; e.target = tg;
        return e;
    endfunction

    initial begin
        ev_t e;
        int  d;
        clear_all();
        rst = 1;
        exp_ctl(0, 0, 0, 0, 0);
        step(); step();
        // Reset state, held and just after release.
        chk_en = 1;
        e_data_chk = 1; e_mepc = 0; e_mcause = 0; e_mtval = 0;
        e_pc_chk = 1; e_rpc = RPC;
        step();
        rst = 0;
        step();

        // ECALL
        clear_all(); commit_valid_i = 1; commit_pc_i = 32'h100; exc_ecall_i = 1; mtvec_i = 32'h800;
        directed("ecall", mk(1, 32'hB, 32'h100, 0, 32'h800), 0);
        // Illegal
        clear_all(); commit_valid_i = 1; commit_pc_i = 32'h40; commit_instr_i = 32'hFFFF_FFFF;
        exc_illegal_i = 1; mtvec_i = 32'h800;
        directed("illegal", mk(1, 32'h2, 32'h40, 32'hFFFF_FFFF, 32'h800), 1);
        // MTI+MEI, vectored
        clear_all(); commit_valid_i = 1; commit_pc_i = 32'h500; irq_i = 32'h880; mie_i = 32'h880;
        mstatus_mie_i = 1; mtvec_i = 32'h1001;
        directed("irq_vec", mk(1, 32'h8000_000B, 32'h500, 0, 32'h102C), 0);
        clear_all(); commit_valid_i = 1; commit_pc_i = 32'h500; irq_i = 32'h880; mie_i = 32'h880;
        mstatus_mie_i = 0; mtvec_i = 32'h1001;
        directed("irq_masked", mk(0, 0, 0, 0, 0), 0);
        // MRET with a busy LSU
        clear_all(); commit_valid_i = 1; commit_pc_i = 32'h700; mret_i = 1; mepc_i = 32'h200;
        directed("mret", mk(2, 0, 0, 0, 32'h200), 3);
        // ld_mis + illegal on one commit
        clear_all(); commit_valid_i = 1; commit_pc_i = 32'h60; commit_instr_i = 32'h1234_5678;
        exc_addr_i = 32'hDEAD_BEEF; exc_ld_mis_i = 1; exc_illegal_i = 1; mtvec_i = 32'h800;
        directed("ld_ill", mk(1, 32'h2, 32'h60, 32'h1234_5678, 32'h800), 0);
        // Vectored target wrap-around
        clear_all(); commit_valid_i = 1; commit_pc_i = 32'h80; irq_i = 32'h800; mie_i = 32'h800;
        mstatus_mie_i = 1; mtvec_i = 32'hFFFF_FFF1;
        directed("wrap", mk(1, 32'h8000_000B, 32'h80, 0, 32'h0000_001C), 0);
        // Invalid commit carrying exception flags
        clear_all(); commit_pc_i = 32'h90; exc_ecall_i = 1;
        directed("no_valid", mk(0, 0, 0, 0, 0), 0);

        // Reset during DRAIN aborts the sequence.
        clear_all(); commit_valid_i = 1; commit_pc_i = 32'h100; exc_ecall_i = 1; mtvec_i = 32'h800;
        exp_ctl(0, 0, 0, 0, 0);
        step();
        clear_commit(); lsu_idle_i = 0;
        exp_ctl(1, 1, 0, 0, 0);
        rst = 1;
        step();
        exp_ctl(0, 0, 0, 0, 0);
        e_data_chk = 1; e_mepc = 0; e_mcause = 0; e_mtval = 0;
        e_pc_chk = 1; e_rpc = RPC;
        rst = 0; lsu_idle_i = 1;
        for (int i = 0; i < 4; i++) step();

        // WFI
        clear_all(); commit_valid_i = 1; commit_pc_i = 32'h300; wfi_i = 1; mie_i = 32'h80;
        mstatus_mie_i = 1; mtvec_i = 32'h900;
`ifdef YARC_TRAP_WFI_EN
        exp_ctl(0, 0, 0, 0, 0);
        step();
        clear_commit();
        for (int i = 0; i < 3; i++) begin exp_ctl(1, 0, 0, 0, 0); step(); end
        irq_i = 32'h80;
        exp_ctl(1, 0, 0, 0, 0);
        step();
        seq_tail(mk(1, 32'h8000_0007, 32'h304, 0, 32'h900), 0);
        // Wake with interrupts globally disabled: just resume.
        clear_all(); commit_valid_i = 1; commit_pc_i = 32'h300; wfi_i = 1; mie_i = 32'h80;
        exp_ctl(0, 0, 0, 0, 0);
        step();
        clear_commit();
        exp_ctl(1, 0, 0, 0, 0); step();
        irq_i = 32'h80;
        exp_ctl(1, 0, 0, 0, 0); step();
        exp_ctl(0, 0, 0, 0, 0); step();
        irq_i = 0;
        step();
`else
        directed("wfi_nop", mk(0, 0, 0, 0, 0), 0);
`endif

        // Randomized commits.
        for (int n = 0; n < 200; n++) begin
            clear_all();
            commit_valid_i   = ($urandom_range(0, 7) != 0);
            commit_pc_i      = $urandom & 32'hFFFF_FFFC;
            commit_instr_i   = $urandom;
            exc_addr_i       = $urandom;
            exc_ifetch_mis_i = ($urandom_range(0, 9) == 0);
            exc_illegal_i    = ($urandom_range(0, 7) == 0);
            exc_ebreak_i     = ($urandom_range(0, 7) == 0);
            exc_ecall_i      = ($urandom_range(0, 7) == 0);
            exc_ld_mis_i     = ($urandom_range(0, 7) == 0);
            exc_st_mis_i     = ($urandom_range(0, 7) == 0);
            mret_i           = ($urandom_range(0, 3) == 0);
`ifndef YARC_TRAP_WFI_EN
            wfi_i            = ($urandom_range(0, 5) == 0);
`endif
            irq_i            = ($urandom_range(0, 2) == 0) ? $urandom : 32'd0;
            mie_i            = $urandom;
            mstatus_mie_i    = 1'($urandom);
            mtvec_i          = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                           : $urandom;
            mepc_i           = $urandom;
            d = $urandom_range(0, 3);
            e = model();
            run_txn(e, d);
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
